// File: rtl/set_assoc_cache.sv
// set_assoc_cache: N-way set-associative, write-through / no-write-allocate
// cache with true-LRU replacement and a block refill FSM toward memory.
//
// Ports
//   clk, reset        clock and synchronous active-high reset
//   req_*             CPU request (valid/ready, byte address, write enable, data)
//   resp_valid/rdata  one-cycle response pulse; read word or write acknowledge (0)
//   mem_req_*         memory request: block read or word write-through
//   mem_wdata         write-through data
//   mem_resp_valid    refill block valid for one cycle (mem_rd_block, word 0 in LSBs)
module set_assoc_cache #(
  parameter int WORD_CAPACITY   = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int WAY_COUNT       = 2,
  parameter int ADDR_BITS       = 32,
  parameter int WORD_BITS       = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [ADDR_BITS-1:0]                 req_addr,
  input  logic                                 req_we,
  input  logic [WORD_BITS-1:0]                 req_wdata,
  output logic                                 resp_valid,
  output logic [WORD_BITS-1:0]                 resp_rdata,
  output logic                                 mem_req_valid,
  input  logic                                 mem_req_ready,
  output logic                                 mem_req_we,
  output logic [ADDR_BITS-1:0]                 mem_req_addr,
  output logic [WORD_BITS-1:0]                 mem_wdata,
  input  logic                                 mem_resp_valid,
  input  logic [WORDS_PER_BLOCK*WORD_BITS-1:0] mem_rd_block
);

  localparam int SETS     = WORD_CAPACITY / (WORDS_PER_BLOCK * WAY_COUNT);
  localparam int BYTE_OFF = $clog2(WORD_BITS / 8);
  localparam int WORD_OFF = $clog2(WORDS_PER_BLOCK);
  localparam int SET_BITS = $clog2(SETS);
  localparam int TAG_BITS = ADDR_BITS - SET_BITS - WORD_OFF - BYTE_OFF;
  localparam int SET_W    = (SETS > 1) ? SET_BITS : 1;
  localparam int WIDX_W   = (WORDS_PER_BLOCK > 1) ? WORD_OFF : 1;
  localparam int WAY_W    = (WAY_COUNT > 1) ? $clog2(WAY_COUNT) : 1;
  localparam int AGE_W    = WAY_W;
  localparam int BLOCK_W  = WORDS_PER_BLOCK * WORD_BITS;
  localparam logic [ADDR_BITS-1:0] BLK_MASK  = {ADDR_BITS{1'b1}} << (WORD_OFF + BYTE_OFF);
  localparam logic [ADDR_BITS-1:0] WORD_MASK = {ADDR_BITS{1'b1}} << BYTE_OFF;

  typedef enum logic [2:0] {IDLE, LOOKUP, RD_REQ, RD_WAIT, RESP, WR_REQ} state_e;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q;
  logic                 we_q;
  logic [WORD_BITS-1:0] wdata_q;
  logic [WAY_W-1:0]     victim_q;

  logic [WAY_COUNT-1:0] valid_q [SETS];
  logic [TAG_BITS-1:0]  tag_q   [SETS][WAY_COUNT];
  logic [BLOCK_W-1:0]   data_q  [SETS][WAY_COUNT];
  logic [AGE_W-1:0]     age_q   [SETS][WAY_COUNT];

  logic [SET_W-1:0]     set_idx;
  logic [WIDX_W-1:0]    word_idx;
  logic [TAG_BITS-1:0]  tag;
  logic                 hit;
  logic [WAY_W-1:0]     hit_way, victim, lru_way;
  logic                 lru_en, refill_en, wr_hit_en;

  function automatic logic [WORD_BITS-1:0] get_word(input logic [BLOCK_W-1:0] blk,
                                                    input logic [WIDX_W-1:0] idx);
    logic [WORD_BITS-1:0] w;
    w = '0;
    for (int i = 0; i < WORDS_PER_BLOCK; i++)
      if (idx == WIDX_W'(i)) w = blk[i*WORD_BITS +: WORD_BITS];
    return w;
  endfunction

  function automatic logic [BLOCK_W-1:0] put_word(input logic [BLOCK_W-1:0] blk,
                                                  input logic [WIDX_W-1:0] idx,
                                                  input logic [WORD_BITS-1:0] w);
    logic [BLOCK_W-1:0] b;
    b = blk;
    for (int i = 0; i < WORDS_PER_BLOCK; i++)
      if (idx == WIDX_W'(i)) b[i*WORD_BITS +: WORD_BITS] = w;
    return b;
  endfunction

  // Fields always come from the latched address, so no req_* input reaches an output.
  assign set_idx  = (SETS > 1) ? addr_q[BYTE_OFF+WORD_OFF +: SET_W] : '0;
  assign word_idx = (WORDS_PER_BLOCK > 1) ? addr_q[BYTE_OFF +: WIDX_W] : '0;
  assign tag      = addr_q[ADDR_BITS-1 -: TAG_BITS];

  // Tag search; scanning upward with a found flag makes the lowest way win.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAY_COUNT; w++) begin
      if (!hit && valid_q[set_idx][w] && (tag_q[set_idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Victim: lowest invalid way, otherwise the oldest (age N-1).
  always_comb begin
    logic found;
    found  = 1'b0;
    victim = '0;
    for (int w = 0; w < WAY_COUNT; w++) begin
      if (!found && !valid_q[set_idx][w]) begin
        found  = 1'b1;
        victim = WAY_W'(w);
      end
    end
    if (!found)
      for (int w = 0; w < WAY_COUNT; w++)
        if (age_q[set_idx][w] == AGE_W'(WAY_COUNT - 1)) victim = WAY_W'(w);
  end

  always_comb begin
    state_d   = state_q;
    lru_en    = 1'b0;
    lru_way   = hit_way;
    refill_en = 1'b0;
    wr_hit_en = 1'b0;
    case (state_q)
      IDLE:    if (req_valid) state_d = LOOKUP;
      LOOKUP: begin
        if (we_q) begin
          state_d   = WR_REQ;
          wr_hit_en = hit;
          lru_en    = hit;
        end else if (hit) begin
          state_d = IDLE;
          lru_en  = 1'b1;
        end else begin
          state_d = RD_REQ;
        end
      end
      RD_REQ:  if (mem_req_ready) state_d = RD_WAIT;
      RD_WAIT: begin
        if (mem_resp_valid) begin
          state_d   = RESP;
          refill_en = 1'b1;
          lru_en    = 1'b1;
          lru_way   = victim_q;
        end
      end
      RESP:    state_d = IDLE;
      WR_REQ:  if (mem_req_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state and latched request; all forced low in reset.
  always_comb begin
    req_ready     = (state_q == IDLE) && !reset;
    resp_valid    = 1'b0;
    resp_rdata    = '0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_wdata     = '0;
    if (!reset) begin
      case (state_q)
        LOOKUP: begin
          if (!we_q && hit) begin
            resp_valid = 1'b1;
            resp_rdata = get_word(data_q[set_idx][hit_way], word_idx);
          end
        end
        RD_REQ: begin
          mem_req_valid = 1'b1;
          mem_req_addr  = addr_q & BLK_MASK;
        end
        RESP: begin
          resp_valid = 1'b1;
          resp_rdata = get_word(data_q[set_idx][victim_q], word_idx);
        end
        WR_REQ: begin
          mem_req_valid = 1'b1;
          mem_req_we    = 1'b1;
          mem_req_addr  = addr_q & WORD_MASK;
          mem_wdata     = wdata_q;
          resp_valid    = mem_req_ready;
        end
        default: ;
      endcase
    end
  end

  // Control state: FSM, valid bits and LRU ages.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAY_COUNT; w++) age_q[s][w] <= AGE_W'(w);
      end
    end else begin
      state_q <= state_d;
      if (refill_en) valid_q[set_idx][victim_q] <= 1'b1;
      // Ways younger than the accessed one age by one; the accessed way becomes MRU.
      if (lru_en) begin
        for (int w = 0; w < WAY_COUNT; w++) begin
          if (WAY_W'(w) == lru_way)
            age_q[set_idx][w] <= '0;
          else if (age_q[set_idx][w] < age_q[set_idx][lru_way])
            age_q[set_idx][w] <= age_q[set_idx][w] + AGE_W'(1);
        end
      end
    end
  end

  // Datapath state: latched request, victim, tags and block data.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && req_valid) begin
      addr_q  <= req_addr;
      we_q    <= req_we;
      wdata_q <= req_wdata;
    end
    if (state_q == LOOKUP) victim_q <= victim;
    if (!reset && refill_en) begin
      data_q[set_idx][victim_q] <= mem_rd_block;
      tag_q[set_idx][victim_q]  <= tag;
    end
    if (!reset && wr_hit_en)
      data_q[set_idx][hit_way] <= put_word(data_q[set_idx][hit_way], word_idx, wdata_q);
  end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Bench for set_assoc_cache with default parameters (4 sets, 2 ways, 4-word blocks).
module tb_set_assoc_cache;
  localparam int NS = 4;
  localparam int NW = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [31:0]  req_addr = '0;
  logic         req_we = 1'b0;
  logic [31:0]  req_wdata = '0;
  logic         resp_valid;
  logic [31:0]  resp_rdata;
  logic         mem_req_valid;
  logic         mem_req_ready = 1'b0;
  logic         mem_req_we;
  logic [31:0]  mem_req_addr;
  logic [31:0]  mem_wdata;
  logic         mem_resp_valid = 1'b0;
  logic [127:0] mem_rd_block = '0;

  set_assoc_cache dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_rd_block(mem_rd_block)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  // Next-level memory: fixed pattern overlaid with written words.
  logic [31:0] wmem [logic [31:0]];

  // Reference cache: per set, the resident blocks with last-use timestamps.
  logic [31:0] m_blk [NS][NW];
  int          m_t   [NS][NW];
  int          m_cnt [NS];
  int          m_clk = 0;

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    int          rdy;
    int          rsp;
    bit          exp_hit;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vt [17];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] ba);
    if (wmem.exists(ba)) return wmem[ba];
    return 32'hD000_0000 ^ ba;
  endfunction

  function automatic logic [127:0] mem_blk(input logic [31:0] a);
    logic [127:0] b;
    for (int i = 0; i < 4; i++) b[i*32 +: 32] = mem_rd((a & ~32'hF) + 32'(4 * i));
    return b;
  endfunction

  function automatic int m_set(input logic [31:0] a);
    return int'((a >> 4) % 32'(NS));
  endfunction

  function automatic int m_find(input logic [31:0] a);
    int s;
    s = m_set(a);
    for (int w = 0; w < m_cnt[s]; w++)
      if (m_blk[s][w] == (a >> 4)) return w;
    return -1;
  endfunction

  task automatic m_clear();
    for (int s = 0; s < NS; s++) m_cnt[s] = 0;
  endtask

  task automatic m_access(input logic [31:0] a, input bit we);
    int s, w, v;
    s = m_set(a);
    w = m_find(a);
    m_clk++;
    if (w >= 0) begin
      m_t[s][w] = m_clk;
    end else if (!we) begin
      if (m_cnt[s] < NW) begin
        v = m_cnt[s];
        m_cnt[s]++;
      end else begin
        v = 0;
        for (int k = 1; k < NW; k++) if (m_t[s][k] < m_t[s][v]) v = k;
      end
      m_blk[s][v] = a >> 4;
      m_t[s][v]   = m_clk;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 1'b0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst:req_ready_in_reset", 32'(req_ready), 32'd0);
    check("rst:resp_valid_in_reset", 32'(resp_valid), 32'd0);
    reset = 1'b0;
    #1;
    check("rst:req_ready", 32'(req_ready), 32'd1);
    check("rst:resp_valid", 32'(resp_valid), 32'd0);
    check("rst:resp_rdata", resp_rdata, 32'd0);
    check("rst:mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst:mem_req_we", 32'(mem_req_we), 32'd0);
    check("rst:mem_req_addr", mem_req_addr, 32'd0);
    check("rst:mem_wdata", mem_wdata, 32'd0);
    m_clear();
  endtask

  // One full CPU transaction with a memory responder; cycle 1 = first cycle after acceptance.
  task automatic run_xact(input string nm, input logic [31:0] a, input bit we,
                          input logic [31:0] wd, input int rdy, input int rsp,
                          input bit exp_hit, input logic [31:0] exp_rd);
    int cyc, nresp, resp_cyc, mem_cyc, nmem, waitc, rsp_at, unstable, rr_bad, exp_lat;
    logic [31:0] got_rd, m_addr, m_data;
    logic        m_we;
    nresp = 0; resp_cyc = -1; mem_cyc = -1; nmem = 0; waitc = 0; rsp_at = -1;
    unstable = 0; rr_bad = 0; got_rd = '0; m_addr = '0; m_data = '0; m_we = 1'b0;
    @(negedge clk);
    #1;
    check({nm, ":req_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_addr = a; req_we = we; req_wdata = wd;
    @(posedge clk);
    cyc = 0;
    while (nresp == 0 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0; req_addr = $urandom; req_we = 1'($urandom_range(0, 1)); req_wdata = $urandom;
      mem_resp_valid = (cyc == rsp_at);
      mem_rd_block = mem_resp_valid ? mem_blk(a) : {$urandom, $urandom, $urandom, $urandom};
      if (mem_req_valid) begin
        if (mem_cyc < 0) begin
          mem_cyc = cyc; m_addr = mem_req_addr; m_we = mem_req_we; m_data = mem_wdata;
        end else if (mem_req_addr !== m_addr || mem_req_we !== m_we || mem_wdata !== m_data) begin
          unstable++;
        end
        waitc++;
      end
      mem_req_ready = mem_req_valid && (waitc > rdy);
      #1;
      if (mem_req_valid && mem_req_ready) begin
        nmem++;
        if (!mem_req_we) rsp_at = cyc + 1 + rsp;
      end
      if (req_ready) rr_bad++;
      if (resp_valid) begin
        nresp++; resp_cyc = cyc; got_rd = resp_rdata;
      end
    end
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    #1;
    check({nm, ":back_to_idle"}, {29'd0, req_ready, resp_valid, mem_req_valid}, 32'd4);
    if (we) exp_lat = 2 + rdy;
    else if (exp_hit) exp_lat = 1;
    else exp_lat = rdy + rsp + 4;
    check({nm, ":resp_cycle"}, resp_cyc, exp_lat);
    check({nm, ":rdata"}, got_rd, we ? 32'd0 : exp_rd);
    check({nm, ":mem_reqs"}, nmem, (!we && exp_hit) ? 32'd0 : 32'd1);
    check({nm, ":stable"}, unstable, 32'd0);
    check({nm, ":req_ready_busy"}, rr_bad, 32'd0);
    if (we || !exp_hit) begin
      check({nm, ":mem_cycle"}, mem_cyc, 32'd2);
      check({nm, ":mem_addr"}, m_addr, we ? (a & ~32'h3) : (a & ~32'hF));
      check({nm, ":mem_we"}, 32'(m_we), 32'(we));
      if (we) check({nm, ":mem_wdata"}, m_data, wd);
    end
  endtask

  // Expectations from the reference model; memory and model updated afterwards.
  task automatic model_xact(input string nm, input logic [31:0] a, input bit we,
                            input logic [31:0] wd, input int rdy, input int rsp);
    run_xact(nm, a, we, wd, rdy, rsp, m_find(a) >= 0, mem_rd(a));
    if (we) wmem[a] = wd;
    m_access(a, we);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, wd;
    bit          we;
    int          bad;

    vt[0]  = '{32'h40, 1'b0, 32'h0,        0, 0, 1'b0, 32'hD000_0040};
    vt[1]  = '{32'h44, 1'b0, 32'h0,        0, 0, 1'b1, 32'hD000_0044};
    vt[2]  = '{32'h00, 1'b0, 32'h0,        1, 1, 1'b0, 32'hD000_0000};
    vt[3]  = '{32'h40, 1'b0, 32'h0,        0, 0, 1'b1, 32'hD000_0040};
    vt[4]  = '{32'h00, 1'b0, 32'h0,        0, 0, 1'b1, 32'hD000_0000};
    vt[5]  = '{32'h80, 1'b0, 32'h0,        0, 3, 1'b0, 32'hD000_0080};
    vt[6]  = '{32'h00, 1'b0, 32'h0,        0, 0, 1'b1, 32'hD000_0000};
    vt[7]  = '{32'h40, 1'b0, 32'h0,        2, 0, 1'b0, 32'hD000_0040};
    vt[8]  = '{32'h44, 1'b1, 32'h1234_5678, 0, 0, 1'b0, 32'h0};
    vt[9]  = '{32'h44, 1'b0, 32'h0,        0, 0, 1'b1, 32'h1234_5678};
    vt[10] = '{32'hC0, 1'b1, 32'hCAFE_F00D, 1, 0, 1'b0, 32'h0};
    vt[11] = '{32'hC0, 1'b0, 32'h0,        0, 0, 1'b0, 32'hCAFE_F00D};
    vt[12] = '{32'h00, 1'b0, 32'h0,        0, 1, 1'b0, 32'hD000_0000};
    vt[13] = '{32'h50, 1'b0, 32'h0,        5, 2, 1'b0, 32'hD000_0050};
    vt[14] = '{32'h54, 1'b1, 32'h0BAD_BEEF, 3, 0, 1'b0, 32'h0};
    vt[15] = '{32'h54, 1'b0, 32'h0,        0, 0, 1'b1, 32'h0BAD_BEEF};
    vt[16] = '{32'h5C, 1'b0, 32'h0,        0, 0, 1'b1, 32'hD000_005C};

    do_reset();

    for (int i = 0; i < 17; i++) begin
      run_xact($sformatf("vec%0d", i), vt[i].addr, vt[i].we, vt[i].wdata,
               vt[i].rdy, vt[i].rsp, vt[i].exp_hit, vt[i].exp_rd);
      if (vt[i].we) wmem[vt[i].addr] = vt[i].wdata;
      m_access(vt[i].addr, vt[i].we);
    end

    for (int i = 0; i < 200; i++) begin
      a  = 32'($urandom_range(0, 63)) << 2;
      we = ($urandom_range(0, 3) == 0);
      wd = $urandom;
      model_xact($sformatf("rnd%0d", i), a, we, wd, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset while waiting for a refill; the late refill must be ignored.
    do_reset();
    model_xact("pre40", 32'h40, 1'b0, 32'h0, 0, 0);
    model_xact("hit40", 32'h40, 1'b0, 32'h0, 0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h80; req_we = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    check("rw:mem_req_valid", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("rw:req_ready_in_reset", 32'(req_ready), 32'd0);
    check("rw:resp_valid_in_reset", 32'(resp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rw:req_ready_after", 32'(req_ready), 32'd1);
    mem_resp_valid = 1'b1;
    mem_rd_block = mem_blk(32'h80);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    bad = 0;
    repeat (3) begin
      #1;
      if (resp_valid || mem_req_valid || !req_ready) bad++;
      @(negedge clk);
    end
    check("rw:quiet_after_reset", bad, 32'd0);
    m_clear();
    model_xact("post40", 32'h40, 1'b0, 32'h0, 0, 0);
    model_xact("post80", 32'h80, 1'b0, 32'h0, 1, 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
